// File: rtl/conv1d_mac_engine_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv1d_mac_engine_if : host control/status and SRAM port bundle. Rev 1.0
// ---------------------------------------------------------------------------
interface conv1d_mac_engine_if #(
  parameter int NUM_WORDS  = 128,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_KERNEL = 16
) ();
  localparam int AW = $clog2(NUM_WORDS);
  localparam int KW = $clog2(MAX_KERNEL) + 1;
  localparam int SW = $clog2(2 * DATA_WIDTH);

  logic                  start_i;
  logic [AW-1:0]         cfg_x_addr_i;
  logic [AW-1:0]         cfg_h_addr_i;
  logic [AW-1:0]         cfg_y_addr_i;
  logic [AW:0]           cfg_len_i;
  logic [KW-1:0]         cfg_klen_i;
  logic                  cfg_same_i;
  logic [SW-1:0]         cfg_shift_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;
  logic                  ext_gnt_o;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [AW-1:0]         mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport master (
    input  start_i, cfg_x_addr_i, cfg_h_addr_i, cfg_y_addr_i, cfg_len_i,
           cfg_klen_i, cfg_same_i, cfg_shift_i, mem_rdata_i,
    output busy_o, done_o, err_o, ext_gnt_o, mem_req_o, mem_we_o,
           mem_addr_o, mem_wdata_o
  );

  modport slave (
    output start_i, cfg_x_addr_i, cfg_h_addr_i, cfg_y_addr_i, cfg_len_i,
           cfg_klen_i, cfg_same_i, cfg_shift_i, mem_rdata_i,
    input  busy_o, done_o, err_o, ext_gnt_o, mem_req_o, mem_we_o,
           mem_addr_o, mem_wdata_o
  );
endinterface
`default_nettype wire

// File: rtl/conv1d_mac_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv1d_mac_engine : SRAM-attached 1-D convolution MAC engine (valid/same).
// Optional CONV1D_SATURATE_EN clamps results instead of wrapping. Rev 1.0
// ---------------------------------------------------------------------------
module conv1d_mac_engine #(
  parameter int NUM_WORDS  = 128,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_KERNEL = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  conv1d_mac_engine_if.master bus
);
  localparam int DW   = DATA_WIDTH;
  localparam int AW   = $clog2(NUM_WORDS);
  localparam int LW   = AW + 1;
  localparam int KW   = $clog2(MAX_KERNEL) + 1;
  localparam int TW   = $clog2(MAX_KERNEL);
  localparam int SW   = $clog2(2 * DW);
  localparam int ACCW = 2 * DW + TW;
  localparam int IW   = AW + KW + 2;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_K   = 3'd1;
  localparam logic [2:0] S_READ_X   = 3'd2;
  localparam logic [2:0] S_ACC_LAST = 3'd3;
  localparam logic [2:0] S_WRITE    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [KW-1:0] c_max_k = KW'(MAX_KERNEL);

  logic [2:0]             r_state, w_next;
  logic [AW-1:0]          r_x_addr, r_h_addr, r_y_addr;
  logic [LW-1:0]          r_len, r_j;
  logic [KW-1:0]          r_klen, r_cnt;
  logic                   r_same;
  logic [SW-1:0]          r_shift;
  logic                   r_err;
  logic                   r_pend;
  logic [TW-1:0]          r_pend_tap;
  logic signed [DW-1:0]   r_tap [MAX_KERNEL];
  logic signed [ACCW-1:0] r_acc;

  logic                   w_cfg_ok, w_kdone, w_xdone, w_last_out, w_in_range;
  logic [KW-1:0]          w_pad;
  logic [LW-1:0]          w_nout;
  logic signed [IW-1:0]   w_idx;
  logic [TW-1:0]          w_cap_idx;
  logic signed [2*DW-1:0] w_prod;
  logic [DW-1:0]          w_result;

  assign w_cfg_ok = (bus.cfg_klen_i != '0) && (bus.cfg_klen_i <= c_max_k) &&
                    (bus.cfg_len_i != '0) &&
                    (bus.cfg_same_i || (IW'(bus.cfg_len_i) >= IW'(bus.cfg_klen_i)));

  assign w_kdone    = (r_cnt == r_klen);
  assign w_xdone    = (r_cnt == r_klen - 1'b1);
  assign w_pad      = r_same ? ((r_klen - 1'b1) >> 1) : '0;
  assign w_nout     = r_same ? r_len : (r_len - LW'(r_klen) + LW'(1));
  assign w_last_out = (r_j == w_nout - LW'(1));
  // Signed sample index j+k-P; negative or >= L means a zero-padding tap.
  assign w_idx      = IW'(r_j) + IW'(r_cnt) - IW'(w_pad);
  assign w_in_range = !w_idx[IW-1] && ($unsigned(w_idx) < IW'(r_len));
  assign w_cap_idx  = TW'(r_cnt - 1'b1);
  assign w_prod     = r_tap[r_pend_tap] * $signed(bus.mem_rdata_i);

`ifdef CONV1D_SATURATE_EN
  logic signed [ACCW-1:0] w_shifted;
  assign w_shifted = r_acc >>> r_shift;
  always_comb begin
    w_result = w_shifted[DW-1:0];
    if (w_shifted[ACCW-1:DW-1] != {(ACCW-DW+1){w_shifted[ACCW-1]}})
      w_result = w_shifted[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end
`else
  assign w_result = DW'(r_acc >>> r_shift);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (bus.start_i) w_next = w_cfg_ok ? S_LOAD_K : S_DONE;
      S_LOAD_K:   if (w_kdone) w_next = S_READ_X;
      S_READ_X:   if (w_xdone) w_next = S_ACC_LAST;
      S_ACC_LAST: w_next = S_WRITE;
      S_WRITE:    w_next = w_last_out ? S_DONE : S_READ_X;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy_o      = 1'b0;
    bus.done_o      = 1'b0;
    bus.ext_gnt_o   = 1'b0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.err_o       = r_err;
    case (r_state)
      S_IDLE:   bus.ext_gnt_o = 1'b1;
      S_LOAD_K: begin
        bus.busy_o     = 1'b1;
        bus.mem_req_o  = !w_kdone;
        bus.mem_addr_o = r_h_addr + AW'(r_cnt);
      end
      S_READ_X: begin
        bus.busy_o     = 1'b1;
        bus.mem_req_o  = w_in_range;
        bus.mem_addr_o = r_x_addr + w_idx[AW-1:0];
      end
      S_ACC_LAST: bus.busy_o = 1'b1;
      S_WRITE: begin
        bus.busy_o      = 1'b1;
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = r_y_addr + r_j[AW-1:0];
        bus.mem_wdata_o = w_result;
      end
      S_DONE:  bus.done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_x_addr   <= '0;
      r_h_addr   <= '0;
      r_y_addr   <= '0;
      r_len      <= '0;
      r_klen     <= '0;
      r_same     <= 1'b0;
      r_shift    <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_j        <= '0;
      r_pend     <= 1'b0;
      r_pend_tap <= '0;
      r_acc      <= '0;
      for (int i = 0; i < MAX_KERNEL; i++) r_tap[i] <= '0;
    end else begin
      r_pend <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_j   <= '0;
          if (bus.start_i) begin
            r_x_addr <= bus.cfg_x_addr_i;
            r_h_addr <= bus.cfg_h_addr_i;
            r_y_addr <= bus.cfg_y_addr_i;
            r_len    <= bus.cfg_len_i;
            r_klen   <= bus.cfg_klen_i;
            r_same   <= bus.cfg_same_i;
            r_shift  <= bus.cfg_shift_i;
            r_err    <= !w_cfg_ok;
          end
        end
        S_LOAD_K: begin
          // Data for the tap requested last cycle arrives now.
          if (r_cnt != '0) r_tap[w_cap_idx] <= $signed(bus.mem_rdata_i);
          r_cnt <= w_kdone ? '0 : r_cnt + 1'b1;
        end
        S_READ_X: begin
          r_pend     <= w_in_range;
          r_pend_tap <= r_cnt[TW-1:0];
          r_cnt      <= w_xdone ? '0 : r_cnt + 1'b1;
        end
        S_WRITE: r_j <= r_j + 1'b1;
        default: ;
      endcase
      if (r_state == S_READ_X && r_cnt == '0)
        r_acc <= '0;
      else if (r_pend)
        r_acc <= r_acc + {{(ACCW-2*DW){w_prod[2*DW-1]}}, w_prod};
    end
  end
endmodule
`default_nettype wire

// File: doc/conv1d_mac_engine.md
CONV1D_MAC_ENGINE -- requirements
Module: conv1d_mac_engine

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 128, words in attached single-port SRAM; AW = clog2(NUM_WORDS).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, signed sample/tap/result width (DW).
REQ-003 SHALL have parameter MAX_KERNEL, default 16, maximum taps; KW = clog2(MAX_KERNEL)+1.
REQ-004 SHALL have ports:
 - clk_i  in  1  clock; all logic on rising edge; single clock.
 - rst_ni  in  1  reset, synchronous, active-low.
 - start_i  in  1  start pulse; sampled only in IDLE.
 - cfg_x_addr_i / cfg_h_addr_i / cfg_y_addr_i  in  AW each  input, kernel, output base word address.
 - cfg_len_i  in  AW+1  input length L.
 - cfg_klen_i  in  KW  kernel length K.
 - cfg_same_i  in  1  0 = valid mode, 1 = same (zero-padded) mode.
 - cfg_shift_i  in  clog2(2*DW)  arithmetic right shift applied to accumulator before narrowing.
 - busy_o  out  1  operation in progress.
 - done_o  out  1  one-cycle completion pulse.
 - err_o  out  1  last start had invalid configuration.
 - ext_gnt_o  out  1  SRAM free for bus access (high iff IDLE).
 - mem_req_o / mem_we_o  out  1 each  SRAM request / write enable (writes full word).
 - mem_addr_o  out  AW  SRAM word address.
 - mem_wdata_o  out  DW  write data.
 - mem_rdata_i  in  DW  read data, valid cycle after read request.

Function
REQ-005 SHALL implement FSM states IDLE, LOAD_K, READ_X, ACC_LAST, WRITE, DONE.
REQ-006 IDLE + start_i + valid config SHALL go LOAD_K; config SHALL be latched at start; start_i outside IDLE SHALL be ignored.
REQ-007 Config invalid if K=0, K>MAX_KERNEL, L=0, or (valid mode and L<K); then IDLE->DONE next cycle, err_o=1, zero memory requests.
REQ-008 LOAD_K SHALL read h[0..K-1] from cfg_h_addr_i+k on K consecutive cycles plus one capture cycle (K+1 cycles) into a tap register file.
REQ-009 Output count N SHALL be L-K+1 (valid) or L (same).
REQ-010 Per output j: READ_X SHALL spend exactly K cycles, cycle k addressing x[j+k-P], P=0 (valid) or floor((K-1)/2) (same); ACC_LAST 1 cycle; WRITE 1 cycle to cfg_y_addr_i+j (K+2 cycles per output).
REQ-011 Out-of-range indices (<0 or >=L) SHALL contribute zero, issue no request, and keep cycle timing unchanged.
REQ-012 Accumulator SHALL be signed, 2*DW+clog2(MAX_KERNEL) bits, cleared at start of each output; products DWxDW signed, full precision.
REQ-013 Result SHALL be accumulator arithmetically shifted right by cfg_shift_i, narrowed to DW per REQ-019.
REQ-014 busy_o SHALL be high for exactly (K+1)+N*(K+2) cycles; done_o SHALL pulse in the following DONE cycle, then IDLE.
REQ-015 err_o SHALL hold until next accepted start_i, cleared at that start.
REQ-016 Addresses SHALL wrap modulo NUM_WORDS; mem_req_o SHALL be 0 in IDLE and DONE.

Reset
REQ-017 With rst_ni low at a clock edge: state IDLE, busy_o=0, done_o=0, err_o=0, ext_gnt_o=1, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, accumulator and taps cleared.
REQ-018 Reset mid-operation SHALL abort with no further write and no done_o pulse.

Configuration
REQ-019 Macro CONV1D_SATURATE_EN: defined -> shifted result clamps to [-2^(DW-1), 2^(DW-1)-1]; undefined -> low DW bits taken (wrap).

Verification
REQ-020 DW=32, K=3 h={1,2,1}, x={1..8}, valid, shift 0 -> y={8,12,16,20,24,28}, busy 34 cycles, one done pulse, err_o=0.
REQ-021 Same mode, K=3 h={1,2,1}, x={1,2,3,4} -> y={4,8,12,11}, busy 24 cycles, no request for x[-1], x[4].
REQ-022 K=1 h={2}, x={0x7FFFFFFF}, shift 0 -> y=0x7FFFFFFF with CONV1D_SATURATE_EN, 0xFFFFFFFE without.
REQ-023 K=4, L=3 valid (also K=0) -> err_o=1, done_o pulse cycle after start, mem_req_o never high.
REQ-024 rst_ni low during READ_X -> next cycle busy_o=0, ext_gnt_o=1, no write; subsequent start of REQ-020 gives identical results.
REQ-025 start_i pulsed while busy -> ignored, ext_gnt_o low throughout, result and cycle count unchanged.
